// File: rtl/config_write_if.sv
// config_write_if: requester handshakes plus the shared config write bus
interface config_write_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic                         out_valid;
  logic [ADDR_BITS-1:0]         out_addr;
  logic [DATA_BITS-1:0]         out_data;
  logic [$clog2(NUM_REQ)-1:0]   out_src;
  logic                         busy;
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, out_valid, out_addr, out_data, out_src, busy
  );
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, out_valid, out_addr, out_data, out_src, busy
  );
endinterface

// File: rtl/config_write_arbiter.sv
// config_write_arbiter: round-robin share of one config bus with a programmable idle gap
module config_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 64,
  parameter int GAP_CYCLES = 0
) (
  input logic           clk,
  input logic           rst,
  config_write_if.slave bus
);
  localparam int SB = $clog2(NUM_REQ);
  logic [SB-1:0] ptr;
  logic [SB-1:0] grant;
  logic [3:0]    gap;
  logic          hit;
  logic          open;
  logic          accept;
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        grant = SB'((int'(ptr) + k) % NUM_REQ);
        hit   = 1'b1;
      end
    end
  end
  assign open          = gap == 4'd0 && (!bus.out_valid || GAP_CYCLES == 0);
  assign accept        = open && hit && !rst;
  assign bus.req_ready = accept ? NUM_REQ'(1) << grant : '0;
  assign bus.busy      = bus.out_valid || gap != 4'd0;
  // the counter runs from the issue cycle, so pulses sit exactly GAP_CYCLES idle cycles apart
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      gap           <= '0;
      ptr           <= '0;
    end else begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_addr <= bus.req_addr[int'(grant)*ADDR_BITS +: ADDR_BITS];
        bus.out_data <= bus.req_data[int'(grant)*DATA_BITS +: DATA_BITS];
        bus.out_src  <= grant;
        ptr          <= grant == SB'(NUM_REQ - 1) ? '0 : grant + 1'b1;
        gap          <= 4'(GAP_CYCLES);
      end else if (gap != 4'd0) begin
        gap <= gap - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_config_write_arbiter.sv
// tb_config_write_arbiter: random requesters on two configurations, scoreboard against a cycle-level model
module tb_config_write_arbiter;
  logic clk = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input int g, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cfg%0d cyc=%0d got=%0h want=%0h", n, g, cyc, a, e);
    end
  endtask

  genvar g, j;
  for (g = 0; g < 2; g++) begin : cfg
    localparam int NR = g ? 2 : 4;
    localparam int GP = g ? 3 : 0;
    localparam int AB = 32;
    localparam int DB = 64;
    typedef struct {int c; logic [AB-1:0] a; logic [DB-1:0] d; int s;} wr_t;
    config_write_if #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
    logic lrst = 1'b1;
    logic [NR-1:0] vld = '0;
    logic [AB-1:0] ra [NR];
    logic [DB-1:0] rd [NR];
    bit fin = 1'b0;
    wr_t q[$];
    int ptr = 0;
    int li = -1000;
    bit seen = 1'b0;
    bit mon_on = 1'b0;
    logic [AB-1:0] last_a = '0;
    logic [DB-1:0] last_d = '0;
    int last_s = 0;

    config_write_arbiter #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB), .GAP_CYCLES(GP)) dut (
      .clk(clk), .rst(lrst), .bus(bus.slave)
    );
    assign bus.req_valid = vld;
    for (j = 0; j < NR; j++) begin : pack
      assign bus.req_addr[j*AB +: AB] = ra[j];
      assign bus.req_data[j*DB +: DB] = rd[j];
    end

    // model: accept allowed GP cycles after the last issue; grant from pointer with wrap
    always @(negedge clk) begin
      logic [NR-1:0] exp_r;
      int gi;
      if (seen) chk("busy", g, 128'(bus.busy), 128'(cyc >= li && (cyc == li || cyc - li < GP)));
      exp_r = '0;
      gi = -1;
      if (!lrst && (GP == 0 || cyc - li >= GP))
        for (int k = 0; k < NR; k++)
          if (gi < 0 && vld[(ptr + k) % NR]) gi = (ptr + k) % NR;
      if (gi >= 0) exp_r[gi] = 1'b1;
      if (seen || lrst) chk("req_ready", g, 128'(bus.req_ready), 128'(exp_r));
      if (lrst) begin
        ptr = 0;
        li = -1000;
        seen = 1'b1;
      end else if (gi >= 0) begin
        q.push_back('{cyc + 1, ra[gi], rd[gi], gi});
        ptr = (gi + 1) % NR;
        li = cyc + 1;
      end
    end

    always @(negedge clk) begin
      bit exp_v;
      exp_v = q.size() > 0 && q[0].c == cyc;
      if (mon_on) begin
        chk("out_valid", g, 128'(bus.out_valid), 128'(exp_v));
        chk("out_addr", g, 128'(bus.out_addr), exp_v ? 128'(q[0].a) : 128'(last_a));
        chk("out_data", g, 128'(bus.out_data), exp_v ? 128'(q[0].d) : 128'(last_d));
        chk("out_src", g, 128'(bus.out_src), exp_v ? 128'(q[0].s) : 128'(last_s));
      end
      if (exp_v) begin
        last_a = q[0].a;
        last_d = q[0].d;
        last_s = q[0].s;
        void'(q.pop_front());
      end
      if (lrst) begin
        last_a = '0;
        last_d = '0;
        last_s = 0;
        mon_on = 1'b1;
      end
    end

    // phases: all busy, odd requesters only, random with withdrawals, random with resets
    initial begin
      logic [NR-1:0] acc;
      for (int i = 0; i < NR; i++) begin
        ra[i] = '0;
        rd[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 lrst = 1'b0;
      for (int ph = 0; ph < 4; ph++) begin
        for (int n = 0; n < 300; n++) begin
          @(negedge clk);
          acc = bus.req_ready & vld;
          @(posedge clk);
          #1;
          lrst = ph == 3 && $urandom_range(0, 39) == 0;
          for (int i = 0; i < NR; i++) begin
            bit drop;
            drop = vld[i] && !acc[i] && ph >= 2 && $urandom_range(0, 7) == 0;
            if (acc[i] || drop) vld[i] = 1'b0;
            if (!vld[i] && !drop && (ph == 0 || (ph == 1 && i % 2 == 1) || (ph >= 2 && $urandom_range(0, 2) == 0))) begin
              vld[i] = 1'b1;
              ra[i] = $urandom;
              rd[i] = {$urandom, $urandom};
            end
          end
        end
      end
      repeat (3) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (cfg[0].fin && cfg[1].fin);
      #500000;
    join_any
    if (!(cfg[0].fin && cfg[1].fin)) begin
      total++;
      bad++;
      $display("FAIL timeout got=not_done want=done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
